// File: rtl/ap_mem_responder.sv
// ap_mem_responder: ap_memory array responder with a host valid/ready preload/readback port
module ap_mem_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 100
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic [ADDR_W-1:0] address0,
  input  logic              ce0,
  input  logic              we0,
  input  logic [DATA_W-1:0] d0,
  output logic [DATA_W-1:0] q0,
  input  logic              h_req_valid,
  output logic              h_req_ready,
  input  logic              h_req_we,
  input  logic [ADDR_W-1:0] h_req_addr,
  input  logic [DATA_W-1:0] h_req_wdata,
  output logic              h_rsp_valid,
  input  logic              h_rsp_ready,
  output logic [DATA_W-1:0] h_rsp_rdata,
  input  logic              clr_stats,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic              oob_err
);
  localparam logic [0:0] IDLE = 1'b0, RSP = 1'b1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0] state;
  logic k_in, h_in, k_rd, k_wr, h_acc;
  logic [DATA_W-1:0] k_q, h_q;
  assign k_in = 32'(address0) < 32'(DEPTH);
  assign h_in = 32'(h_req_addr) < 32'(DEPTH);
  assign k_rd = ce0 & ~we0;
  assign k_wr = ce0 & we0;
  assign k_q = k_in ? mem[address0] : '0;
  assign h_q = h_in ? mem[h_req_addr] : '0;
  // kernel owns the array whenever ce0 is high, so the host only gets idle cycles
  assign h_req_ready = (state == IDLE) & ~ce0;
  assign h_acc = h_req_valid & h_req_ready;
  assign h_rsp_valid = state == RSP;
  always_ff @(posedge ap_clk) begin
    if (k_wr && k_in) mem[address0] <= d0;
    else if (h_acc && h_req_we && h_in) mem[h_req_addr] <= h_req_wdata;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      q0          <= '0;
      state       <= IDLE;
      h_rsp_rdata <= '0;
      rd_count    <= '0;
      wr_count    <= '0;
      oob_err     <= 1'b0;
    end else begin
      q0          <= k_rd ? k_q : q0;
      state       <= (state == IDLE) ? (h_acc ? RSP : IDLE) : (h_rsp_ready ? IDLE : RSP);
      h_rsp_rdata <= h_acc ? (h_req_we ? '0 : h_q) : h_rsp_rdata;
      rd_count    <= clr_stats ? '0 : (k_rd && rd_count != '1) ? rd_count + 32'd1 : rd_count;
      wr_count    <= clr_stats ? '0 : (k_wr && wr_count != '1) ? wr_count + 32'd1 : wr_count;
      oob_err     <= clr_stats ? 1'b0 : oob_err | (ce0 & ~k_in) | (h_acc & ~h_in);
    end
  end
endmodule

// File: tb/tb_ap_mem_responder.sv
// tb_ap_mem_responder: directed plus randomized checks of ap_mem_responder against an array model
module tb_ap_mem_responder;
  logic        ap_clk = 0;
  logic        ap_rst_n;
  logic [6:0]  address0;
  logic        ce0, we0;
  logic [31:0] d0, q0;
  logic        h_req_valid, h_req_ready, h_req_we;
  logic [6:0]  h_req_addr;
  logic [31:0] h_req_wdata;
  logic        h_rsp_valid, h_rsp_ready;
  logic [31:0] h_rsp_rdata;
  logic        clr_stats;
  logic [31:0] rd_count, wr_count;
  logic        oob_err;
  int checks = 0, errors = 0;
  logic [31:0] model [100];
  int exp_rd = 0, exp_wr = 0;
  logic exp_oob = 0;
  logic [31:0] exp_q = 0, rd;

  ap_mem_responder dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .address0(address0), .ce0(ce0), .we0(we0),
    .d0(d0), .q0(q0), .h_req_valid(h_req_valid), .h_req_ready(h_req_ready),
    .h_req_we(h_req_we), .h_req_addr(h_req_addr), .h_req_wdata(h_req_wdata),
    .h_rsp_valid(h_rsp_valid), .h_rsp_ready(h_rsp_ready), .h_rsp_rdata(h_rsp_rdata),
    .clr_stats(clr_stats), .rd_count(rd_count), .wr_count(wr_count), .oob_err(oob_err)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mread(input int a);
    return (a < 100) ? model[a] : 32'd0;
  endfunction

  task automatic host_xfer(input logic we, input logic [6:0] a, input logic [31:0] wd, output logic [31:0] r);
    h_req_valid = 1; h_req_we = we; h_req_addr = a; h_req_wdata = wd;
    #1;
    for (int i = 0; i < 20 && !h_req_ready; i++) step();
    chk("host_req_ready", h_req_ready, 1);
    step();
    h_req_valid = 0;
    chk("host_rsp_next_cycle", h_rsp_valid, 1);
    r = h_rsp_rdata;
    if (we && a < 100) model[a] = wd;
    if (a >= 100) exp_oob = 1;
    step();
  endtask

  task automatic kop(input logic we, input logic [6:0] a, input logic [31:0] d);
    ce0 = 1; we0 = we; address0 = a; d0 = d;
    step();
    ce0 = 0; we0 = 0;
    if (we) begin
      exp_wr++;
      if (a < 100) model[a] = d;
    end else begin
      exp_rd++;
      exp_q = mread(a);
    end
    if (a >= 100) exp_oob = 1;
  endtask

  initial begin
    ap_rst_n = 0; address0 = 0; ce0 = 0; we0 = 0; d0 = 0;
    h_req_valid = 0; h_req_we = 0; h_req_addr = 0; h_req_wdata = 0;
    h_rsp_ready = 1; clr_stats = 0;
    step(); step();
    ap_rst_n = 1;
    #1;
    chk("rst_q0", q0, 0);
    chk("rst_rsp_valid", h_rsp_valid, 0);
    chk("rst_rsp_rdata", h_rsp_rdata, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_oob", oob_err, 0);
    chk("rst_req_ready", h_req_ready, 1);
    step();

    for (int i = 0; i < 100; i++) begin
      host_xfer(1, 7'(i), 32'(1000 + i), rd);
      if (i == 0) chk("write_ack_rdata", rd, 0);
    end
    host_xfer(0, 0, 0, rd);  chk("preload_rd0", rd, 1000);
    host_xfer(0, 57, 0, rd); chk("preload_rd57", rd, 1057);
    host_xfer(0, 99, 0, rd); chk("preload_rd99", rd, 1099);
    chk("host_not_counted", rd_count, 0);

    for (int a = 1; a < 100; a++) begin
      ce0 = 1; we0 = 0; address0 = 7'(a);
      step();
      chk("stream_q0", q0, 32'(1000 + a));
      exp_rd++;
    end
    ce0 = 0; exp_q = 1099;
    chk("stream_rd_count", rd_count, 99);
    step();
    chk("q0_hold", q0, 1099);

    h_req_valid = 1; h_req_we = 0; h_req_addr = 7;
    for (int i = 0; i < 5; i++) begin
      ce0 = 1; we0 = 0; address0 = 2;
      #1;
      chk("collide_ready_low", h_req_ready, 0);
      step();
      exp_rd++;
    end
    ce0 = 0;
    #1;
    chk("collide_ready_6th", h_req_ready, 1);
    step();
    h_req_valid = 0;
    chk("collide_rsp_valid", h_rsp_valid, 1);
    chk("collide_rdata", h_rsp_rdata, 1007);
    chk("collide_q0", q0, 1002);
    chk("collide_rd_count", rd_count, 32'(exp_rd));
    step();

    kop(1, 100, 32'hDEAD);
    chk("oob_set", oob_err, 1);
    kop(0, 100, 0);
    chk("oob_read_q0", q0, 0);
    chk("oob_rd_count", rd_count, 32'(exp_rd));
    chk("oob_wr_count", wr_count, 1);
    host_xfer(0, 99, 0, rd); chk("oob_mem99_intact", rd, 1099);
    clr_stats = 1; ce0 = 1; we0 = 0; address0 = 100;
    step();
    clr_stats = 0; ce0 = 0;
    exp_rd = 0; exp_wr = 0; exp_oob = 0; exp_q = 0;
    chk("clr_oob", oob_err, 0);
    chk("clr_rd_count", rd_count, 0);
    chk("clr_wr_count", wr_count, 0);
    kop(1, 10, 32'h1234_5678);
    kop(0, 10, 0);
    chk("write_then_read", q0, 32'h1234_5678);

    h_rsp_ready = 0; h_req_valid = 1; h_req_we = 0; h_req_addr = 5;
    step();
    h_req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_rsp_valid", h_rsp_valid, 1);
      chk("bp_rdata", h_rsp_rdata, 1005);
      chk("bp_req_ready", h_req_ready, 0);
      step();
    end
    h_rsp_ready = 1;
    #1;
    chk("bp_rsp_valid_last", h_rsp_valid, 1);
    step();
    chk("bp_done_valid", h_rsp_valid, 0);
    chk("bp_done_ready", h_req_ready, 1);

    h_rsp_ready = 0; h_req_valid = 1; h_req_we = 0; h_req_addr = 6;
    step();
    h_req_valid = 0;
    chk("rsp_before_reset", h_rsp_valid, 1);
    #2 ap_rst_n = 0;
    #1;
    chk("reset_async_valid", h_rsp_valid, 0);
    chk("reset_async_rdata", h_rsp_rdata, 0);
    chk("reset_async_rd_count", rd_count, 0);
    step();
    ap_rst_n = 1; h_rsp_ready = 1;
    exp_rd = 0; exp_wr = 0; exp_oob = 0; exp_q = 0;
    step();
    host_xfer(0, 3, 0, rd); chk("after_reset_rd3", rd, 1003);

    for (int n = 0; n < 300; n++) begin
      int op;
      logic [6:0] a;
      logic [31:0] d;
      op = int'($urandom_range(0, 3));
      a = 7'($urandom_range(0, 127));
      d = $urandom;
      if (op < 2) kop(op[0], a, d);
      else begin
        host_xfer(op[0], a, d, rd);
        chk("rand_host_rdata", rd, op[0] ? 32'd0 : mread(a));
      end
      chk("rand_q0", q0, exp_q);
    end
    chk("rand_rd_count", rd_count, 32'(exp_rd));
    chk("rand_wr_count", wr_count, 32'(exp_wr));
    chk("rand_oob", oob_err, exp_oob);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ap_mem_responder.md
# ap_mem_responder

Memory-side responder for the single-port `ap_memory` interface that our HLS kernels drive (`*_address0`, `*_ce0`, `*_we0`, `*_d0`, `*_q0`).
- It holds the array contents and answers kernel reads with one-cycle latency.
- It also exposes a host-side valid/ready port, so the testbench or system controller can preload and read back the array between kernel invocations.
- One instance sits behind each array argument of a kernel, for example the `a`, `b` and `c` arrays of the vector-add kernel.

## Interface
Parameters:
- `DATA_W`, default 32: word width.
- `ADDR_W`, default 7: address width.
- `DEPTH`, default 100: number of valid words, at addresses 0..DEPTH-1.

Ports:
- `ap_clk`  in  1  clock; everything is on the rising edge.
- `ap_rst_n`  in  1  reset, asynchronous and active-low.
- `address0`  in  ADDR_W  kernel address.
- `ce0`  in  1  kernel access enable.
- `we0`  in  1  kernel write enable; qualified by `ce0`.
- `d0`  in  DATA_W  kernel write data.
- `q0`  out  DATA_W  kernel read data.
- `h_req_valid`  in  1  host request valid.
- `h_req_ready`  out  1  host request ready.
- `h_req_we`  in  1  host request type: 1 = write, 0 = read.
- `h_req_addr`  in  ADDR_W  host address.
- `h_req_wdata`  in  DATA_W  host write data.
- `h_rsp_valid`  out  1  host response valid.
- `h_rsp_ready`  in  1  host response ready.
- `h_rsp_rdata`  out  DATA_W  host read data; 0 for write acknowledges.
- `clr_stats`  in  1  synchronous clear of the counters and `oob_err`.
- `rd_count`  out  32  number of kernel reads.
- `wr_count`  out  32  number of kernel writes.
- `oob_err`  out  1  sticky out-of-range access flag.

## Operation
- Storage: DEPTH x DATA_W register array. Reset does not clear it; contents are undefined until written.
- Kernel read (`ce0`=1, `we0`=0):
  - `q0` <= mem[`address0`] at the next edge.
  - `q0` holds its value in every cycle without a kernel read.
- Kernel write (`ce0`=1, `we0`=1):
  - mem[`address0`] <= `d0`; `q0` is unchanged (no write-through).
- Out of range (`address0` >= DEPTH, from either port):
  - Writes are dropped; reads return 0.
  - `oob_err` is set and stays set until `clr_stats` or reset.
- Kernel priority:
  - `h_req_ready` = (state == IDLE) & ~`ce0`, combinational on `ce0`.
  - The host therefore never accesses the array in the same cycle as the kernel.
- Host FSM, two states:
  - IDLE: on `h_req_valid` & `h_req_ready`, perform the access in that cycle and go to RSP.
    - Write: mem[`h_req_addr`] <= `h_req_wdata`; `h_rsp_rdata` <= 0.
    - Read: `h_rsp_rdata` <= mem[`h_req_addr`].
  - RSP: `h_rsp_valid`=1. `h_rsp_rdata` is held stable until `h_rsp_ready`=1, then the FSM returns to IDLE. `h_req_ready`=0 while in RSP.
- Counters:
  - `rd_count` increments on each kernel read; `wr_count` increments on each kernel write. Out-of-range accesses are counted.
  - Both saturate at 32'hFFFFFFFF.
  - Host accesses are not counted.
- `clr_stats` zeroes both counters and `oob_err`. It wins over a coincident increment or error in the same cycle.

## Timing
- Reset values: `q0`=0, `h_rsp_valid`=0, `h_rsp_rdata`=0, `rd_count`=0, `wr_count`=0, `oob_err`=0, FSM=IDLE.
- `h_req_ready`=1 after reset, provided `ce0`=0.
- Kernel read latency is 1 cycle (address in cycle N, `q0` valid in cycle N+1), which matches the HLS `ap_memory` read latency of 1.
- Back-to-back kernel reads return one word per cycle. A write in cycle N is visible to a read issued in cycle N+1.
- Host: acceptance in cycle N gives `h_rsp_valid`=1 in cycle N+1. With `h_rsp_ready` held at 1, maximum throughput is one request per 2 cycles.
- Host request while `ce0`=1: stalled, with no loss. The request is accepted in the first cycle with `ce0`=0 and the FSM in IDLE.
- Reset mid-operation: asynchronous return to the reset values. A pending host response is discarded; array contents are retained.
- `oob_err` and the counters update one edge after the offending or counted access.

## Test plan
- Host preload: write mem[0..99] = 1000+i, read back addresses 0, 57 and 99.
  - Required: rdata 1000, 1057, 1099; each response one cycle after acceptance.
- Kernel streaming: `ce0`=1, `we0`=0, addresses 1..99 on consecutive cycles.
  - Required: `q0` = 1000+addr one cycle later on every cycle; `rd_count`=99.
- Collision: host read request held while the kernel asserts `ce0` for 5 cycles.
  - Required: `h_req_ready`=0 for those 5 cycles; accepted on the 6th; rdata correct.
- Out of range: kernel write to address 100 with `d0`=0xDEAD, then kernel read of address 100.
  - Required: `q0`=0, `oob_err`=1, mem[99] still 1099; `clr_stats` then gives `oob_err`=0 and both counters 0.
- Response backpressure: `h_rsp_ready`=0 for 4 cycles after a read of address 5.
  - Required: `h_rsp_valid` and rdata=1005 held stable; `h_req_ready`=0 until the handshake completes.
- Reset during RSP: deassert `ap_rst_n` while `h_rsp_valid`=1.
  - Required: `h_rsp_valid`=0 immediately; after release, a host read of address 3 returns 1003.
